// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard controller bundle: stage register fields in, pipeline register controls out.
// master = datapath side (drives stage fields, consumes controls); slave = controller.
// Ports: ID/EX/MEM/WB register numbers and flags, load enables, bubbles, forward selects, stall count.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic [4:0]       ex_rs;
    logic [4:0]       ex_rt;
    logic [4:0]       idex_rd;
    logic             idex_reg_write;
    logic             idex_mem_read;
    logic             ex_is_multi;
    logic             ex_branch_taken;
    logic [4:0]       exmem_rd;
    logic             exmem_reg_write;
    logic [4:0]       memwb_rd;
    logic             memwb_reg_write;

    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_write;
    logic             idex_bubble;
    logic             exmem_bubble;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             busy;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rs, ex_rt,
               idex_rd, idex_reg_write, idex_mem_read, ex_is_multi, ex_branch_taken,
               exmem_rd, exmem_reg_write, memwb_rd, memwb_reg_write,
        input  pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
               exmem_bubble, fwd_a, fwd_b, busy, stall_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rs, ex_rt,
               idex_rd, idex_reg_write, idex_mem_read, ex_is_multi, ex_branch_taken,
               exmem_rd, exmem_reg_write, memwb_rd, memwb_reg_write,
        output pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
               exmem_bubble, fwd_a, fwd_b, busy, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: stall/flush/freeze sequencing, EX forwarding selects,
// multi-cycle EX occupancy FSM and a saturating stall-cycle counter.
// Zero-latency combinational controls; only state, cnt and stall_cnt are registered.
// Ports: clk, rst (async active-high), hz (slave modport of pipe_hazard_ctrl_if).
// Option: define HAZARD_FORWARDING_EN to enable forwarding (load-use-only stalls);
// otherwise forward selects are 00 and any EX/MEM-stage producer match stalls.
module pipe_hazard_ctrl #(
    parameter int MULTI_LAT = 4,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_ctrl_if.slave hz
);
    localparam int CW = $clog2(MULTI_LAT) + 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(MULTI_LAT - 1);

    typedef enum logic {RUN, MULTI} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          freeze;
    logic          multi_busy;
    logic          hazard;

    function automatic logic src_match(input logic uses, input logic [4:0] src,
                                       input logic wr, input logic [4:0] dst);
        return uses && (src != 5'd0) && wr && (src == dst);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic mem_wr, input logic [4:0] mem_rd,
                                           input logic wb_wr, input logic [4:0] wb_rd);
        if (src_match(1'b1, src, mem_wr, mem_rd))
            return 2'b10;
        else if (src_match(1'b1, src, wb_wr, wb_rd))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    // The RUN cycle that sees the op plus MULTI_LAT-1 counted MULTI cycles freeze;
    // the MULTI cycle with cnt==0 lets the op leave EX while still reporting busy.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        freeze     = 1'b0;
        multi_busy = 1'b0;
        case (state)
            RUN: begin
                if (hz.ex_is_multi) begin
                    freeze     = 1'b1;
                    multi_busy = 1'b1;
                    state_nxt  = MULTI;
                    cnt_nxt    = CNT_LOAD;
                end
            end
            MULTI: begin
                multi_busy = 1'b1;
                if (cnt != '0) begin
                    freeze  = 1'b1;
                    cnt_nxt = cnt - 1'b1;
                end else begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

`ifdef HAZARD_FORWARDING_EN
    // Forwarding covers everything except a load whose data is not yet available.
    always_comb begin
        hazard = hz.idex_mem_read &&
                 (src_match(hz.id_uses_rs, hz.id_rs, hz.idex_reg_write, hz.idex_rd) ||
                  src_match(hz.id_uses_rt, hz.id_rt, hz.idex_reg_write, hz.idex_rd));
    end
    assign hz.fwd_a = rst ? 2'b00 : fwd_sel(hz.ex_rs, hz.exmem_reg_write, hz.exmem_rd,
                                           hz.memwb_reg_write, hz.memwb_rd);
    assign hz.fwd_b = rst ? 2'b00 : fwd_sel(hz.ex_rt, hz.exmem_reg_write, hz.exmem_rd,
                                           hz.memwb_reg_write, hz.memwb_rd);
`else
    // No forwarding: wait until the producer reaches WB; write-first RF covers WB.
    always_comb begin
        hazard = src_match(hz.id_uses_rs, hz.id_rs, hz.idex_reg_write,  hz.idex_rd)  ||
                 src_match(hz.id_uses_rt, hz.id_rt, hz.idex_reg_write,  hz.idex_rd)  ||
                 src_match(hz.id_uses_rs, hz.id_rs, hz.exmem_reg_write, hz.exmem_rd) ||
                 src_match(hz.id_uses_rt, hz.id_rt, hz.exmem_reg_write, hz.exmem_rd);
    end
    assign hz.fwd_a = 2'b00;
    assign hz.fwd_b = 2'b00;
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{hz.ex_rs, hz.ex_rt, hz.idex_mem_read,
                                 hz.memwb_rd, hz.memwb_reg_write};
`endif

    // Priority: reset, freeze, flush, stall, normal.
    always_comb begin
        hz.pc_write     = 1'b1;
        hz.ifid_write   = 1'b1;
        hz.ifid_flush   = 1'b0;
        hz.idex_write   = 1'b1;
        hz.idex_bubble  = 1'b0;
        hz.exmem_bubble = 1'b0;
        hz.busy         = multi_busy;
        if (rst) begin
            hz.pc_write     = 1'b0;
            hz.ifid_write   = 1'b0;
            hz.ifid_flush   = 1'b1;
            hz.idex_bubble  = 1'b1;
            hz.exmem_bubble = 1'b1;
            hz.busy         = 1'b0;
        end else if (freeze) begin
            hz.pc_write     = 1'b0;
            hz.ifid_write   = 1'b0;
            hz.idex_write   = 1'b0;
            hz.exmem_bubble = 1'b1;
            hz.busy         = 1'b1;
        end else if (hz.ex_branch_taken) begin
            hz.ifid_flush  = 1'b1;
            hz.idex_bubble = 1'b1;
        end else if (hazard) begin
            hz.pc_write    = 1'b0;
            hz.ifid_write  = 1'b0;
            hz.idex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            hz.stall_cnt <= '0;
        else if (!hz.pc_write && (hz.stall_cnt != '1))
            hz.stall_cnt <= hz.stall_cnt + 1'b1;
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cmp_cnt = 0;
    int   err_cnt = 0;
    int   exp_stall = 0;
    int   frz_cycles;
    int   busy_cycles;

    pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

    pipe_hazard_ctrl #(.MULTI_LAT(4), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        cmp_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven 1ns after the edge, checks follow 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        hz.id_rs = 0; hz.id_rt = 0; hz.id_uses_rs = 0; hz.id_uses_rt = 0;
        hz.ex_rs = 0; hz.ex_rt = 0; hz.idex_rd = 0; hz.idex_reg_write = 0;
        hz.idex_mem_read = 0; hz.ex_is_multi = 0; hz.ex_branch_taken = 0;
        hz.exmem_rd = 0; hz.exmem_reg_write = 0; hz.memwb_rd = 0; hz.memwb_reg_write = 0;
    endtask

    task automatic set_load_use();
        hz.idex_mem_read = 1; hz.idex_reg_write = 1; hz.idex_rd = 19;
        hz.id_rs = 19; hz.id_uses_rs = 1;
    endtask

    initial begin
        clear_inputs();
        #1;
        chk("rst_pc_write", hz.pc_write, 0);
        chk("rst_ifid_write", hz.ifid_write, 0);
        chk("rst_idex_write", hz.idex_write, 1);
        chk("rst_ifid_flush", hz.ifid_flush, 1);
        chk("rst_idex_bubble", hz.idex_bubble, 1);
        chk("rst_exmem_bubble", hz.exmem_bubble, 1);
        chk("rst_busy", hz.busy, 0);
        chk("rst_fwd", {hz.fwd_a, hz.fwd_b}, 0);
        tick(); tick();
        chk("rst_stall_cnt", hz.stall_cnt, 0);
        rst = 0;
        #1;
        chk("post_rst_pc_write", hz.pc_write, 1);
        chk("post_rst_flush", hz.ifid_flush, 0);
        chk("post_rst_fwd", {hz.fwd_a, hz.fwd_b}, 0);

        // Zero register and unused sources never hazard.
        tick();
        hz.idex_reg_write = 1; hz.idex_mem_read = 1; hz.idex_rd = 0;
        hz.id_rs = 0; hz.id_uses_rs = 1; #1;
        chk("r0_no_stall", hz.pc_write, 1);
        hz.idex_rd = 7; hz.id_rs = 7; hz.id_uses_rs = 0; #1;
        chk("unused_no_stall", hz.pc_write, 1);
        clear_inputs();

`ifdef HAZARD_FORWARDING_EN
        tick();
        set_load_use(); #1;
        chk("lu_pc_write", hz.pc_write, 0);
        chk("lu_idex_bubble", hz.idex_bubble, 1);
        tick(); exp_stall += 1;
        clear_inputs();
        hz.exmem_rd = 19; hz.exmem_reg_write = 1; hz.ex_rs = 19; #1;
        chk("lu_next_pc_write", hz.pc_write, 1);
        chk("lu_next_fwd_a", hz.fwd_a, 2);
        chk("lu_stall_cnt", hz.stall_cnt, exp_stall);
        clear_inputs();
        hz.exmem_rd = 20; hz.exmem_reg_write = 1;
        hz.memwb_rd = 20; hz.memwb_reg_write = 1; hz.ex_rt = 20; #1;
        chk("fwd_b_prio", hz.fwd_b, 2);
        hz.ex_rt = 0; #1;
        chk("fwd_b_r0", hz.fwd_b, 0);
        hz.exmem_rd = 3; hz.ex_rt = 20; #1;
        chk("fwd_b_wb", hz.fwd_b, 1);
        clear_inputs();
        hz.idex_reg_write = 1; hz.idex_rd = 9; hz.id_rt = 9; hz.id_uses_rt = 1; #1;
        chk("alu_raw_no_stall", hz.pc_write, 1);
        clear_inputs();
`else
        tick();
        hz.exmem_rd = 21; hz.exmem_reg_write = 1; hz.id_rt = 21; hz.id_uses_rt = 1;
        hz.ex_rt = 21; #1;
        chk("nf_mem_stall", hz.pc_write, 0);
        chk("nf_mem_bubble", hz.idex_bubble, 1);
        chk("nf_fwd_tied", hz.fwd_b, 0);
        tick(); exp_stall += 1;
        clear_inputs();
        hz.memwb_rd = 21; hz.memwb_reg_write = 1; hz.id_rt = 21; hz.id_uses_rt = 1; #1;
        chk("nf_wb_no_stall", hz.pc_write, 1);
        chk("nf_stall_cnt", hz.stall_cnt, exp_stall);
        clear_inputs();
        hz.idex_reg_write = 1; hz.idex_rd = 5; hz.id_rs = 5; hz.id_uses_rs = 1; #1;
        chk("nf_ex_stall", hz.ifid_write, 0);
        tick(); exp_stall += 1;
        hz.idex_reg_write = 0; #1;
        chk("nf_ex_nowr", hz.pc_write, 1);
        clear_inputs();
`endif

        // Branch beats a simultaneous load-use hazard.
        tick();
        set_load_use(); hz.ex_branch_taken = 1; #1;
        chk("br_pc_write", hz.pc_write, 1);
        chk("br_ifid_flush", hz.ifid_flush, 1);
        chk("br_idex_bubble", hz.idex_bubble, 1);
        tick();
        clear_inputs(); #1;
        chk("br_stall_cnt", hz.stall_cnt, exp_stall);

        // Single multi-cycle op: 4 freeze cycles, 5 busy cycles.
        frz_cycles = 0; busy_cycles = 0;
        hz.ex_is_multi = 1;
        for (int i = 0; i < 5; i++) begin
            hz.ex_branch_taken = (i == 1); #1;
            if (i == 1) chk("frz_ignores_branch", hz.ifid_flush, 0);
            if (hz.exmem_bubble && !hz.idex_write) frz_cycles++;
            if (hz.busy) busy_cycles++;
            tick();
        end
        clear_inputs(); #1;
        exp_stall += 4;
        chk("multi_freeze", frz_cycles, 4);
        chk("multi_busy", busy_cycles, 5);
        chk("multi_done_busy", hz.busy, 0);
        chk("multi_done_pc", hz.pc_write, 1);
        chk("multi_stall_cnt", hz.stall_cnt, exp_stall);

        // Back-to-back multi ops: second re-freezes with no gap.
        frz_cycles = 0; busy_cycles = 0;
        hz.ex_is_multi = 1;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (hz.exmem_bubble && !hz.idex_write) frz_cycles++;
            if (hz.busy) busy_cycles++;
            tick();
        end
        clear_inputs(); #1;
        exp_stall += 8;
        chk("b2b_freeze", frz_cycles, 8);
        chk("b2b_busy", busy_cycles, 10);
        chk("b2b_stall_cnt", hz.stall_cnt, exp_stall);

        // Reset mid-cycle in MULTI aborts the op.
        tick();
        hz.ex_is_multi = 1;
        tick(); tick();
        #2 rst = 1; #1;
        chk("abort_busy", hz.busy, 0);
        chk("abort_stall_cnt", hz.stall_cnt, 0);
        chk("abort_pc_write", hz.pc_write, 0);
        chk("abort_exmem_bubble", hz.exmem_bubble, 1);
        tick();
        rst = 0; hz.ex_is_multi = 0; #1;
        chk("abort_run_busy", hz.busy, 0);
        chk("abort_run_pc", hz.pc_write, 1);

        // Saturation of the stall counter.
        tick();
        set_load_use();
        for (int i = 0; i < 20; i++) tick();
        chk("stall_cnt_sat", hz.stall_cnt, 15);
        clear_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central hazard controller for the 5-stage pipelined processor (`Top_pipeline`). It sequences the pipeline registers by stalling, flushing and freezing them, and drives the EX-stage forwarding muxes. It also owns the multi-cycle EX occupancy of mult/div instructions through a small state machine and counter, and keeps a saturating stall-cycle performance counter. It sits beside the datapath, reads stage register fields, and drives the write enables and bubble controls of PC, IF/ID, ID/EX and EX/MEM.

## Interface
- `MULTI_LAT`, default 4: extra EX cycles for a multi-cycle op (≥1). EX occupancy is `MULTI_LAT`+1.
- `CNT_W`, default 16: width of the stall counter.

- `clk`  in  1  pipeline clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `id_rs`, `id_rt`  in  5  source registers of the instruction in ID
- `id_uses_rs`, `id_uses_rt`  in  1  ID instruction reads rs / rt
- `ex_rs`, `ex_rt`  in  5  source registers of the instruction in EX
- `idex_rd`  in  5  destination of the instruction in EX
- `idex_reg_write`, `idex_mem_read`  in  1  EX instruction writes a reg / is a load
- `ex_is_multi`  in  1  EX instruction is mult/div
- `ex_branch_taken`  in  1  branch resolved taken in EX
- `exmem_rd`, `exmem_reg_write`  in  5/1  MEM-stage destination / write flag
- `memwb_rd`, `memwb_reg_write`  in  5/1  WB-stage destination / write flag
- `pc_write`  out  1  PC load enable
- `ifid_write`  out  1  IF/ID load enable
- `ifid_flush`  out  1  zero IF/ID
- `idex_write`  out  1  ID/EX load enable
- `idex_bubble`  out  1  load NOP into ID/EX
- `exmem_bubble`  out  1  load NOP into EX/MEM
- `fwd_a`, `fwd_b`  out  2  EX operand select: 00 reg file, 10 EX/MEM, 01 MEM/WB
- `busy`  out  1  multi-cycle op occupying EX
- `stall_cnt`  out  `CNT_W`  cycles with `pc_write`=0, saturating

## Operation
- States: RUN and MULTI. `cnt` is a `$clog2(MULTI_LAT)+1`-bit down counter.
- The controller applies these conditions in priority order. Each one is evaluated combinationally in the current cycle.
  1. rst
  2. FREEZE: RUN with `ex_is_multi`=1, or MULTI with `cnt`≠0.
  3. FLUSH: `ex_branch_taken`=1.
  4. STALL: a load-use or RAW hazard.
  5. Normal operation.
- FREEZE outputs: `pc_write`=0, `ifid_write`=0, `idex_write`=0, `exmem_bubble`=1, `busy`=1. `ex_branch_taken` and hazard checks are ignored.
- RUN→MULTI: taken when `ex_is_multi`=1; loads `cnt`←`MULTI_LAT`-1.
- In MULTI:
  - `cnt`≠0: freeze and decrement.
  - `cnt`=0: no freeze, `busy`=1, the op advances, next state is RUN.
- FLUSH outputs: `pc_write`=1, `ifid_flush`=1, `idex_bubble`=1. FLUSH overrides STALL in the same cycle.
- STALL outputs: `pc_write`=0, `ifid_write`=0, `idex_bubble`=1.
- Hazard match rules:
  - A match requires the relevant `id_uses_*` flag set.
  - A match requires a nonzero register number.
  - A match requires the producer's write flag set.
  - Register 0 never hazards or forwards.
- Forwarding (EX operands):
  - `fwd_a`=10 when `exmem_reg_write` is set and `exmem_rd`=`ex_rs`≠0.
  - Otherwise `fwd_a`=01 when `memwb_reg_write` is set and `memwb_rd`=`ex_rs`≠0.
  - Otherwise `fwd_a`=00.
  - `fwd_b` follows the same rules using `ex_rt`.
  - EX/MEM wins over MEM/WB.
- Normal operation: `pc_write`, `ifid_write` and `idex_write` are 1; `ifid_flush`, `idex_bubble` and `exmem_bubble` are 0.
- `stall_cnt` increments at each rising edge where `pc_write`=0 and rst=0. It holds at 2^`CNT_W`-1.

## Timing
- rst high forces state RUN, `cnt`=0 and `stall_cnt`=0 immediately.
- Output values while rst is high: `pc_write`=0, `ifid_write`=0, `idex_write`=1, `ifid_flush`=1, `idex_bubble`=1, `exmem_bubble`=1, `fwd_a`=00, `fwd_b`=00, `busy`=0.
- Release of rst is sampled at the first rising edge after deassertion.
- All control outputs are combinational from the inputs and state, with zero latency. Only state, `cnt` and `stall_cnt` are registered.
- Load-use stall lasts exactly 1 cycle with forwarding.
- A multi op freezes the pipe for `MULTI_LAT` cycles.
- Back-to-back multi ops re-freeze in the cycle the second one reaches EX, with no gap cycle.
- Asserting rst during MULTI aborts the sequence. The first cycle after release is RUN.

## Configuration
- `HAZARD_FORWARDING_EN` defined:
  - Forwarding is active.
  - STALL is raised only for load-use: `idex_mem_read`=1 and `idex_rd` matches a used `id_rs`/`id_rt`.
- `HAZARD_FORWARDING_EN` undefined:
  - `fwd_a` and `fwd_b` are tied to 00.
  - STALL is raised when a used ID source matches `idex_rd` (with `idex_reg_write`) or `exmem_rd` (with `exmem_reg_write`).
  - A WB-stage match does not stall; the register file is write-first.

## Test plan
- **Reset.** Assert rst mid-cycle → all outputs immediately take their reset values and `stall_cnt`=0. After release, `pc_write`=1 and `fwd_a`=`fwd_b`=00.
- **Load-use (forwarding on).** `idex_mem_read`=1, `idex_rd`=19, `id_rs`=19 → 1 cycle with `pc_write`=0 and `idex_bubble`=1. The next cycle has `fwd_a`=10 for `ex_rs`=19, and `stall_cnt`=1.
- **Forward priority.** `exmem_rd`=`memwb_rd`=20 (both writing) and `ex_rt`=20 → `fwd_b`=10. With `ex_rt`=0 → `fwd_b`=00.
- **Branch with hazard.** `ex_branch_taken`=1 together with a load-use match → `pc_write`=1, `ifid_flush`=1, `idex_bubble`=1, and `stall_cnt` is unchanged.
- **Multi-cycle op (`MULTI_LAT`=4).**
  - Single op: `ex_is_multi`=1 → `exmem_bubble`=1 and `idex_write`=0 for exactly 4 cycles, `busy` for 5, then RUN. `stall_cnt` rises by 4.
  - Back-to-back: two ops in sequence → 8 freeze cycles in total.
- **Forwarding off.** With `HAZARD_FORWARDING_EN` undefined, `exmem_rd`=21 writing and `id_rt`=21 used → STALL for 1 cycle. A WB match with `memwb_rd`=21 causes no stall.
